// File: rtl/stream_uart_emitter.sv
// stream_uart_emitter
//
// Accepts an 8-bit AXI-Stream byte stream, buffers it in a FIFO and serialises
// each byte as one 8N1/8N2 UART frame on a single TX pin. Frames abut with no
// idle cycle while the FIFO has data.
//
// Optional feature (compile-time macro STREAM_UART_EMITTER_EOL_EN):
//   when defined, a byte stored with tlast=1 is followed by two extra frames,
//   0x0D then 0x0A, before the next FIFO entry is popped. When undefined, tlast
//   is stored but ignored.
//
// Parameters:
//   BAUD_DIV   - clock cycles per UART bit (>= 2)
//   FIFO_DEPTH - byte-buffer entries (power of two, >= 2)
//   STOP_BITS  - stop bits per frame (1 or 2)
//
// Ports:
//   i_clk     - clock
//   i_rst     - synchronous active-high reset
//   i_tdata   - stream byte
//   i_tlast   - last byte of packet
//   i_tvalid  - stream valid
//   o_tready  - stream ready (registered, low while FIFO is full)
//   o_uart_tx - UART line, idles high (registered)
//   o_busy    - frame on the line or FIFO non-empty (registered)
//   o_level   - FIFO occupancy

module stream_uart_emitter #(
  parameter int unsigned BAUD_DIV   = 868,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [7:0]                   i_tdata,
  input  logic                         i_tlast,
  input  logic                         i_tvalid,
  output logic                         o_tready,
  output logic                         o_uart_tx,
  output logic                         o_busy,
  output logic [$clog2(FIFO_DEPTH):0]  o_level
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW  = AddrW + 1;
  localparam int unsigned BaudW = $clog2(BAUD_DIV);

  localparam logic [BaudW-1:0] BaudMax = BaudW'(BAUD_DIV - 1);
  localparam logic [2:0]       StopMax = 3'(STOP_BITS - 1);
  localparam logic [LvlW-1:0]  LvlFull = LvlW'(FIFO_DEPTH);

`ifdef STREAM_UART_EMITTER_EOL_EN
  // StEolCr / StEolLf are the start-bit phases of the inserted CR / LF frames.
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StEolCr, StEolLf} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  // ---------------------------------------------------------------------------
  // FIFO: {tlast, tdata} entries
  // ---------------------------------------------------------------------------
  logic [8:0]       mem_q [FIFO_DEPTH];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]  count_q, count_d;
  logic             tready_q;
  logic             push, pop, fifo_nempty;
  logic [8:0]       rd_data;

  assign push        = i_tvalid & tready_q;
  assign fifo_nempty = (count_q != '0);
  assign rd_data     = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + LvlW'(1);
      2'b01:   count_d = count_q - LvlW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tready_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      count_q  <= count_d;
      // Ready reflects the occupancy after this edge, so a pop re-opens it next cycle.
      tready_q <= (count_d != LvlFull);
    end
  end

  // Storage needs no reset; occupancy and pointers define validity.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= {i_tlast, i_tdata};
  end

  // ---------------------------------------------------------------------------
  // TX FSM
  // ---------------------------------------------------------------------------
  state_e           state_q;
  logic [BaudW-1:0] baud_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shreg_q;
  logic             last_q;
  logic             bit_end, stop_done, eol_next, start_phase;

  assign bit_end   = (baud_q == '0);
  assign stop_done = (state_q == StStop) && bit_end && (bit_cnt_q == '0);

`ifdef STREAM_UART_EMITTER_EOL_EN
  // Set while the frame on the line is the inserted CR, so LF follows it.
  logic eol_cr_q;

  assign eol_next    = last_q | eol_cr_q;
  assign start_phase = (state_q == StStart) || (state_q == StEolCr) || (state_q == StEolLf);
`else
  logic unused_last;

  assign unused_last = last_q;
  assign eol_next    = 1'b0;
  assign start_phase = (state_q == StStart);
`endif

  // Pop from idle, or back-to-back at the end of a stop phase when no EOL is pending.
  assign pop = fifo_nempty && ((state_q == StIdle) || (stop_done && !eol_next));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      last_q    <= 1'b0;
`ifdef STREAM_UART_EMITTER_EOL_EN
      eol_cr_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            shreg_q <= rd_data[7:0];
            last_q  <= rd_data[8];
            baud_q  <= BaudMax;
            state_q <= StStart;
          end
        end

`ifdef STREAM_UART_EMITTER_EOL_EN
        StStart, StEolCr, StEolLf: begin
`else
        StStart: begin
`endif
          if (bit_end) begin
            baud_q    <= BaudMax;
            bit_cnt_q <= 3'd7;
            state_q   <= StData;
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end

        StData: begin
          if (bit_end) begin
            baud_q  <= BaudMax;
            shreg_q <= {1'b0, shreg_q[7:1]};
            if (bit_cnt_q == '0) begin
              bit_cnt_q <= StopMax;
              state_q   <= StStop;
            end else begin
              bit_cnt_q <= bit_cnt_q - 1'b1;
            end
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end

        StStop: begin
          if (!bit_end) begin
            baud_q <= baud_q - 1'b1;
          end else if (bit_cnt_q != '0) begin
            bit_cnt_q <= bit_cnt_q - 1'b1;
            baud_q    <= BaudMax;
          end else begin
            baud_q <= BaudMax;
`ifdef STREAM_UART_EMITTER_EOL_EN
            if (last_q) begin
              shreg_q  <= 8'h0D;
              last_q   <= 1'b0;
              eol_cr_q <= 1'b1;
              state_q  <= StEolCr;
            end else if (eol_cr_q) begin
              shreg_q  <= 8'h0A;
              eol_cr_q <= 1'b0;
              state_q  <= StEolLf;
            end else
`endif
            if (pop) begin
              shreg_q <= rd_data[7:0];
              last_q  <= rd_data[8];
              state_q <= StStart;
            end else begin
              state_q <= StIdle;
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs; the line follows the FSM phase by one cycle.
  // ---------------------------------------------------------------------------
  logic line_bit;
  logic tx_q, busy_q;

  always_comb begin
    line_bit = 1'b1;
    if (start_phase) begin
      line_bit = 1'b0;
    end else if (state_q == StData) begin
      line_bit = shreg_q[0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      tx_q   <= line_bit;
      busy_q <= (state_q != StIdle) || fifo_nempty;
    end
  end

  assign o_tready  = tready_q;
  assign o_uart_tx = tx_q;
  assign o_busy    = busy_q;
  assign o_level   = count_q;

endmodule

// File: tb/tb_stream_uart_emitter.sv
// Bench for stream_uart_emitter: two instances (BAUD_DIV=4, FIFO_DEPTH=16,
// STOP_BITS=1 and 2) checked every cycle against a frame-level queue model,
// plus hand-computed literal expectations.

module tb_stream_uart_emitter;

  localparam int Baud  = 4;
  localparam int Depth = 16;
`ifdef STREAM_UART_EMITTER_EOL_EN
  localparam bit EolEn = 1'b1;
`else
  localparam bit EolEn = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      tv, tl;
  logic [1:0][7:0] td;
  logic [1:0]      tx, rdy, busy;
  logic [1:0][4:0] lvl;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  stream_uart_emitter #(.BAUD_DIV(Baud), .FIFO_DEPTH(Depth), .STOP_BITS(1)) dut_s1 (
    .i_clk(clk), .i_rst(rst), .i_tdata(td[0]), .i_tlast(tl[0]), .i_tvalid(tv[0]),
    .o_tready(rdy[0]), .o_uart_tx(tx[0]), .o_busy(busy[0]), .o_level(lvl[0])
  );

  stream_uart_emitter #(.BAUD_DIV(Baud), .FIFO_DEPTH(Depth), .STOP_BITS(2)) dut_s2 (
    .i_clk(clk), .i_rst(rst), .i_tdata(td[1]), .i_tlast(tl[1]), .i_tvalid(tv[1]),
    .o_tready(rdy[1]), .o_uart_tx(tx[1]), .o_busy(busy[1]), .o_level(lvl[1])
  );

  // ---------------------------------------------------------------------------
  // Reference model: a FIFO of bytes and a "cycles left in current frame" count.
  // Expected outputs after an edge are derived from the state before that edge.
  // ---------------------------------------------------------------------------
  logic [8:0] m_buf [2][Depth];
  int         m_head [2];
  int         m_cnt  [2];
  int         m_rem  [2];
  int         m_eol  [2];
  bit         m_bits [2][44];
  logic [1:0] m_tx, m_busy, m_rdy, m_push;
  int         m_lvl  [2];

  function automatic int fl(input int i);
    return (i == 0) ? 10 * Baud : 11 * Baud;
  endfunction

  task automatic load_frame(input int i, input logic [7:0] b);
    for (int k = 0; k < fl(i); k++) begin
      if (k < Baud)              m_bits[i][k] = 1'b0;
      else if (k < 9 * Baud)     m_bits[i][k] = b[(k - Baud) / Baud];
      else                       m_bits[i][k] = 1'b1;
    end
    m_rem[i] = fl(i);
  endtask

  task automatic model_step(input int i);
    int         cnt_pre;
    logic [8:0] ent;
    bit         popped;
    if (rst) begin
      m_cnt[i] = 0; m_head[i] = 0; m_rem[i] = 0; m_eol[i] = 0;
      m_tx[i] = 1'b1; m_busy[i] = 1'b0; m_rdy[i] = 1'b0; m_push[i] = 1'b0; m_lvl[i] = 0;
      return;
    end
    cnt_pre   = m_cnt[i];
    m_push[i] = tv[i] & m_rdy[i];
    m_tx[i]   = (m_rem[i] > 0) ? m_bits[i][fl(i) - m_rem[i]] : 1'b1;
    m_busy[i] = (m_rem[i] > 0) || (cnt_pre > 0);
    if (m_push[i]) m_buf[i][(m_head[i] + cnt_pre) % Depth] = {tl[i], td[i]};
    popped = 1'b0;
    if (m_rem[i] > 1) begin
      m_rem[i]--;
    end else if (m_rem[i] == 1 && m_eol[i] > 0) begin
      load_frame(i, (m_eol[i] == 2) ? 8'h0D : 8'h0A);
      m_eol[i]--;
    end else if (cnt_pre > 0) begin
      ent       = m_buf[i][m_head[i]];
      m_head[i] = (m_head[i] + 1) % Depth;
      popped    = 1'b1;
      load_frame(i, ent[7:0]);
      if (EolEn && ent[8]) m_eol[i] = 2;
    end else begin
      m_rem[i] = 0;
    end
    m_cnt[i] = cnt_pre + int'(m_push[i]) - int'(popped);
    m_lvl[i] = m_cnt[i];
    m_rdy[i] = (m_cnt[i] < Depth);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_head[i] = 0; m_rem[i] = 0; m_eol[i] = 0; m_lvl[i] = 0;
    end
    m_tx = 2'b11; m_busy = '0; m_rdy = '0; m_push = '0;
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s: got=%0h want=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < 2; i++) begin
          check($sformatf("model_tx[%0d]", i),    32'(tx[i]),   32'(m_tx[i]));
          check($sformatf("model_ready[%0d]", i), 32'(rdy[i]),  32'(m_rdy[i]));
          check($sformatf("model_busy[%0d]", i),  32'(busy[i]), 32'(m_busy[i]));
          check($sformatf("model_level[%0d]", i), 32'(lvl[i]),  32'(m_lvl[i]));
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic push_one(input int i, input logic [7:0] d, input logic l);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    tv[i] = 1'b1; td[i] = d; tl[i] = l;
    for (int w = 0; w < 400 && !ok; w++) begin
      @(negedge clk);
      if (m_push[i]) ok = 1'b1;
    end
    tv[i] = 1'b0;
    if (!ok) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int w = 0; w < 8000 && !ok; w++) begin
      @(negedge clk);
      if (m_rem[0] == 0 && m_rem[1] == 0 && m_cnt[0] == 0 && m_cnt[1] == 0) ok = 1'b1;
    end
    @(negedge clk);
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
  endtask

  int idx  [2];
  int maxl [2];
  int endk;
  int p;

  initial begin
    tv = '0; tl = '0; td = '0; rst = 1'b1;
    repeat (3) @(posedge clk);
    chk_en = 1'b1;

    // Reset values.
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_tx",    32'(tx[i]),   32'd1);
      check("rst_ready", 32'(rdy[i]),  32'd0);
      check("rst_busy",  32'(busy[i]), 32'd0);
      check("rst_level", 32'(lvl[i]),  32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) check("ready_after_rst", 32'(rdy[i]), 32'd1);

    // Single byte 0x55 into both instances at edge N.
    @(negedge clk);
    tv = 2'b11; td[0] = 8'h55; td[1] = 8'h55; tl = '0;
    @(negedge clk);
    tv = '0;
    for (int k = 1; k <= 46; k++) begin
      @(negedge clk);
      if (k == 1)  check("single_n1_tx", 32'(tx[0]), 32'd1);
      if (k == 2)  check("single_n2_tx", 32'(tx[0]), 32'd0);
      if (k == 6)  check("single_bit0",  32'(tx[0]), 32'd1);
      if (k == 10) check("single_bit1",  32'(tx[0]), 32'd0);
      if (k == 41) check("single_busy41", 32'(busy[0]), 32'd1);
      if (k == 42) check("single_tx42",   32'(tx[0]),   32'd1);
      if (k == 42) check("single_busy42", 32'(busy[0]), 32'd0);
      if (k == 45) check("two_stop_busy45", 32'(busy[1]), 32'd1);
      if (k == 46) check("two_stop_busy46", 32'(busy[1]), 32'd0);
    end
    wait_idle();

    // Two stop bits: 0xA3 on the STOP_BITS=2 instance.
    push_one(1, 8'hA3, 1'b0);
    for (int k = 1; k <= 46; k++) begin
      @(negedge clk);
      if (k == 2)  check("a3_start", 32'(tx[1]), 32'd0);
      if (k == 33) check("a3_bit6",  32'(tx[1]), 32'd0);
      if (k == 38) check("a3_stop_first", 32'(tx[1]), 32'd1);
      if (k == 45) check("a3_stop_last",  32'(tx[1]), 32'd1);
      if (k == 45) check("a3_busy45", 32'(busy[1]), 32'd1);
      if (k == 46) check("a3_busy46", 32'(busy[1]), 32'd0);
    end
    wait_idle();

    // EOL: 0x41 with tlast=1; three frames when the feature is built in.
    endk = EolEn ? 122 : 42;
    push_one(0, 8'h41, 1'b1);
    for (int k = 1; k <= 125; k++) begin
      @(negedge clk);
      if (k == endk - 1) check("eol_busy_before_end", 32'(busy[0]), 32'd1);
      if (k == endk)     check("eol_busy_end",        32'(busy[0]), 32'd0);
    end
    wait_idle();

    // Burst of 20 bytes with valid held high.
    for (int i = 0; i < 2; i++) begin idx[i] = 0; maxl[i] = 0; end
    @(negedge clk);
    tv = 2'b11; td[0] = 8'h00; td[1] = 8'h00; tl = '0;
    for (int c = 0; c < 3000 && (idx[0] < 20 || idx[1] < 20); c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (m_push[i]) idx[i]++;
        if (idx[i] < 20) td[i] = 8'(idx[i]);
        else             tv[i] = 1'b0;
        if (int'(lvl[i]) > maxl[i]) maxl[i] = int'(lvl[i]);
      end
    end
    tv = '0;
    wait_idle();
    for (int i = 0; i < 2; i++) begin
      check("burst_count",     32'(idx[i]),  32'd20);
      check("burst_max_level", 32'(maxl[i]), 32'd16);
      check("burst_end_level", 32'(lvl[i]),  32'd0);
    end

    // Simultaneous push and pop with one byte queued.
    for (int i = 0; i < 2; i++) begin
      push_one(i, 8'hC1, 1'b0);
      push_one(i, 8'hC2, 1'b0);
      repeat (fl(i) - 2) @(negedge clk);
      check("pushpop_level_before", 32'(lvl[i]), 32'd1);
      tv[i] = 1'b1; td[i] = 8'hC3;
      @(negedge clk);
      tv[i] = 1'b0;
      check("pushpop_level_after", 32'(lvl[i]), 32'd1);
      wait_idle();
    end

    // Reset during DATA bit 3 with bytes queued.
    @(negedge clk);
    tv = 2'b11; td[0] = 8'h30; td[1] = 8'h30;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      td[0] = 8'(8'h30 + k); td[1] = 8'(8'h30 + k);
    end
    @(negedge clk);
    tv = '0;
    repeat (13) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("midrst_tx",    32'(tx[i]),  32'd1);
      check("midrst_level", 32'(lvl[i]), 32'd0);
      check("midrst_ready", 32'(rdy[i]), 32'd0);
    end
    rst = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      check("post_rst_tx",   32'(tx[0] & tx[1]),   32'd1);
      check("post_rst_busy", 32'(busy[0] | busy[1]), 32'd0);
    end

    // Randomised traffic, alternating light and heavy load, rare resets.
    for (int seg = 0; seg < 4; seg++) begin
      p = (seg % 2 == 0) ? 8 : 70;
      for (int c = 0; c < 800; c++) begin
        @(negedge clk);
        rst = ($urandom_range(0, 599) == 0);
        for (int i = 0; i < 2; i++) begin
          tv[i] = ($urandom_range(0, 99) < p);
          td[i] = 8'($urandom);
          tl[i] = ($urandom_range(0, 3) == 0);
        end
      end
    end
    @(negedge clk);
    tv = '0; rst = 1'b0;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
